// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, instruction
// constants, fetch FSM state type and small arithmetic helpers.
package fetch_unit_pkg;

    localparam int PC_WIDTH     = 10;
    localparam int INSTR_WIDTH  = 9;
    localparam int OFFSET_WIDTH = 8;
    localparam int COUNT_WIDTH  = 16;

    localparam logic [INSTR_WIDTH-1:0] INSTR_HALT = 9'h1FF;
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = 16'hFFFF;

    // Opcode field is the top three instruction bits; HALT is the all-ones word.
    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_SETDIR = 3'd4;
    localparam logic [2:0] OP_SYS    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    function automatic logic [2:0] instr_opcode(input logic [INSTR_WIDTH-1:0] instr);
        return instr[INSTR_WIDTH-1:INSTR_WIDTH-3];
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] cnt);
        return (cnt == COUNT_MAX) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit, the instruction ROM and the control unit.
// The slave modport is the fetch unit's view; master is the environment's.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                    start;
    logic [PC_WIDTH-1:0]     inst_addr;
    logic [INSTR_WIDTH-1:0]  inst_data;
    logic [INSTR_WIDTH-1:0]  instruction;
    logic                    inst_valid;
    logic                    stall;
    logic                    branch_enable;
    logic                    branch_taken;
    logic [OFFSET_WIDTH-1:0] branch_offset;
    logic                    write_branch_dir;
    logic                    branch_dir_in;
    logic                    done;
    logic [COUNT_WIDTH-1:0]  inst_count;
    // Debug preload of the retired-instruction counter.
    logic                    count_load;
    logic [COUNT_WIDTH-1:0]  count_load_val;

    modport slave (
        input  start, inst_data, stall, branch_enable, branch_taken,
               branch_offset, write_branch_dir, branch_dir_in,
               count_load, count_load_val,
        output inst_addr, instruction, inst_valid, done, inst_count
    );

    modport master (
        output start, inst_data, stall, branch_enable, branch_taken,
               branch_offset, write_branch_dir, branch_dir_in,
               count_load, count_load_val,
        input  inst_addr, instruction, inst_valid, done, inst_count
    );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC arithmetic: sequential step or forward/backward relative branch,
// all modulo 2**PC_WIDTH.
module pc_next
    import fetch_unit_pkg::*;
(
    input  logic [PC_WIDTH-1:0]     i_pc,
    input  logic                    i_branch,
    input  logic                    i_dir,
    input  logic [OFFSET_WIDTH-1:0] i_offset,
    output logic [PC_WIDTH-1:0]     o_pc_next
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0] w_offset_ext;

    assign w_offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){1'b0}}, i_offset};

    // Select the next PC; wrap-around falls out of the fixed-width add/subtract.
    always_comb begin
        o_pc_next = i_pc + PC_ONE;
        if (i_branch && i_dir) begin
            o_pc_next = i_pc - w_offset_ext;
        end else if (i_branch) begin
            o_pc_next = i_pc + w_offset_ext;
        end else begin
            o_pc_next = i_pc + PC_ONE;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC/DONE sequencer owning the PC,
// instruction register, branch direction and retired-instruction counter.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    fetch_unit_if.slave bus
);

    fetch_state_t           r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic                   r_branch_dir;
    logic [COUNT_WIDTH-1:0] r_inst_count;
    logic                   r_inst_valid;
    logic                   r_done;

    logic [PC_WIDTH-1:0]    w_pc_next;
    logic                   w_branch_taken;

    assign w_branch_taken = bus.branch_enable & bus.branch_taken;

    pc_next u_pc_next (
        .i_pc      (r_pc),
        .i_branch  (w_branch_taken),
        .i_dir     (r_branch_dir),
        .i_offset  (bus.branch_offset),
        .o_pc_next (w_pc_next)
    );

    // Fetch sequencer; outputs are registered alongside the state they track.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= {PC_WIDTH{1'b0}};
            r_ir         <= {INSTR_WIDTH{1'b0}};
            r_branch_dir <= 1'b0;
            r_inst_count <= {COUNT_WIDTH{1'b0}};
            r_inst_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state      <= ST_FETCH;
                        r_pc         <= {PC_WIDTH{1'b0}};
                        r_inst_count <= {COUNT_WIDTH{1'b0}};
                        r_done       <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_state      <= ST_EXEC;
                    r_ir         <= bus.inst_data;
                    r_inst_valid <= 1'b1;
                end
                ST_EXEC: begin
                    // A stalled cycle changes nothing; the branch sees the old direction.
                    if (!bus.stall) begin
                        r_inst_count <= sat_inc(r_inst_count);
                        r_inst_valid <= 1'b0;
                        if (bus.write_branch_dir) begin
                            r_branch_dir <= bus.branch_dir_in;
                        end
                        if (r_ir == INSTR_HALT) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            r_pc    <= w_pc_next;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_inst_valid <= 1'b0;
                    r_done       <= 1'b0;
                end
            endcase
            if (bus.count_load) begin
                r_inst_count <= bus.count_load_val;
            end
        end
    end

    assign bus.inst_addr   = r_pc;
    assign bus.instruction = r_ir;
    assign bus.inst_valid  = r_inst_valid;
    assign bus.done        = r_done;
    assign bus.inst_count  = r_inst_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-instruction vectors plus
// hand-written sequences for HALT, reset mid-instruction and counter saturation.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk;
    logic rst;
    fetch_unit_if bus();

    fetch_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [8:0] rom [0:1023];
    assign bus.inst_data = rom[bus.inst_addr];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         stall;
        bit         snoise;
        bit         fnoise;
        bit         br_en;
        bit         br_tk;
        logic [7:0] off;
        bit         wdir;
        bit         dirin;
        int         exp_pc;
        int         exp_cnt;
    } vec_t;

    vec_t vecs [17];
    vec_t pv;

    always #5 clk = ~clk;

    function automatic logic [8:0] rom_word(input int a);
        logic [7:0] lo;
        lo = a[7:0];
        return {1'b0, lo};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_noise(input bit on);
        bus.branch_enable    = on;
        bus.branch_taken     = on;
        bus.branch_offset    = on ? 8'd50 : 8'd0;
        bus.write_branch_dir = on;
        bus.branch_dir_in    = on;
        bus.start            = on;
    endtask

    // Called #1 after the edge that enters FETCH; returns #1 after the next FETCH entry.
    task automatic run_vec(input vec_t v, input int cur_pc);
        check("fetch_addr", int'(bus.inst_addr), cur_pc);
        check("fetch_valid", int'(bus.inst_valid), 0);
        if (v.fnoise) drive_noise(1'b1);
        @(posedge clk); #1;
        drive_noise(1'b0);
        bus.count_load = 1'b0;
        check("exec_valid", int'(bus.inst_valid), 1);
        check("exec_ir", int'(bus.instruction), int'(rom_word(cur_pc)));
        check("exec_addr", int'(bus.inst_addr), cur_pc);
        if (v.stall > 0) begin
            bus.stall = 1'b1;
            if (v.snoise) drive_noise(1'b1);
            for (int k = 0; k < v.stall; k++) begin
                @(posedge clk); #1;
                check("stall_valid", int'(bus.inst_valid), 1);
                check("stall_addr", int'(bus.inst_addr), cur_pc);
                check("stall_cnt", int'(bus.inst_count), v.exp_cnt - 1);
            end
        end
        bus.stall            = 1'b0;
        bus.start            = 1'b0;
        bus.branch_enable    = v.br_en;
        bus.branch_taken     = v.br_tk;
        bus.branch_offset    = v.off;
        bus.write_branch_dir = v.wdir;
        bus.branch_dir_in    = v.dirin;
        @(posedge clk); #1;
        drive_noise(1'b0);
        check("next_pc", int'(bus.inst_addr), v.exp_pc);
        check("count", int'(bus.inst_count), v.exp_cnt);
        check("post_valid", int'(bus.inst_valid), 0);
        check("post_done", int'(bus.done), 0);
    endtask

    initial begin
        int cyc;
        int cur;
        int addrs [$];

        //            stall snz   fnz   en    tk    off     wdir  dirin exp_pc cnt
        vecs[0]  = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1,    1};
        vecs[1]  = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 2,    2};
        vecs[2]  = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 3,    3};
        vecs[3]  = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2,   1'b1, 1'b1, 4,    4};
        vecs[4]  = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd6,   1'b0, 1'b0, 1022, 5};
        vecs[5]  = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3,   1'b1, 1'b0, 1019, 6};
        vecs[6]  = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd15,  1'b0, 1'b0, 10,   7};
        vecs[7]  = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5,   1'b0, 1'b0, 15,   8};
        vecs[8]  = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1, 16,   9};
        vecs[9]  = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd6,   1'b0, 1'b0, 10,   10};
        vecs[10] = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5,   1'b1, 1'b0, 11,   11};
        vecs[11] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   1'b0, 1'b0, 11,   12};
        vecs[12] = '{0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd9,   1'b0, 1'b0, 12,   13};
        vecs[13] = '{2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 13,   14};
        vecs[14] = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd10,  1'b0, 1'b0, 23,   15};
        vecs[15] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0, 278,  16};
        vecs[16] = '{3, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 279,  17};

        for (int i = 0; i < 1024; i++) rom[i] = rom_word(i);
        rom[3] = INSTR_HALT;

        clk = 1'b0;
        rst = 1'b1;
        drive_noise(1'b0);
        bus.stall          = 1'b0;
        bus.count_load     = 1'b0;
        bus.count_load_val = 16'h0000;

        repeat (2) @(posedge clk); #1;
        check("rst_addr", int'(bus.inst_addr), 0);
        check("rst_ir", int'(bus.instruction), 0);
        check("rst_valid", int'(bus.inst_valid), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_cnt", int'(bus.inst_count), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("idle_valid", int'(bus.inst_valid), 0);
        check("idle_addr", int'(bus.inst_addr), 0);

        // Three plain words then HALT: Done on cycle 9 after the Start edge.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 20) begin
            if (!bus.inst_valid) addrs.push_back(int'(bus.inst_addr));
            @(posedge clk); #1;
            cyc++;
        end
        check("halt_done", int'(bus.done), 1);
        check("halt_cycle", cyc, 9);
        check("halt_nfetch", addrs.size(), 4);
        for (int i = 0; i < addrs.size() && i < 4; i++) check("halt_addr_seq", addrs[i], i);
        check("halt_cnt", int'(bus.inst_count), 4);
        repeat (2) @(posedge clk); #1;
        check("done_hold", int'(bus.done), 1);
        check("done_pc", int'(bus.inst_addr), 3);
        check("done_ir", int'(bus.instruction), int'(INSTR_HALT));
        check("done_cnt", int'(bus.inst_count), 4);
        check("done_valid", int'(bus.inst_valid), 0);
        rom[3] = rom_word(3);

        // Restart from DONE and walk the vector table.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("restart_done", int'(bus.done), 0);
        check("restart_cnt", int'(bus.inst_count), 0);
        cur = 0;
        for (int i = 0; i < 17; i++) begin
            run_vec(vecs[i], cur);
            cur = vecs[i].exp_pc;
        end

        // Reset mid-EXEC at PC 7 with Start held high throughout the run.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            check("run_addr", int'(bus.inst_addr), i);
            @(posedge clk); #1;
            check("run_valid", int'(bus.inst_valid), 1);
            @(posedge clk); #1;
        end
        check("pc7_addr", int'(bus.inst_addr), 7);
        @(posedge clk); #1;
        check("pc7_valid", int'(bus.inst_valid), 1);
        check("pc7_cnt", int'(bus.inst_count), 7);
        rst = 1'b1;
        #1;
        check("arst_addr", int'(bus.inst_addr), 0);
        check("arst_valid", int'(bus.inst_valid), 0);
        check("arst_cnt", int'(bus.inst_count), 0);
        check("arst_ir", int'(bus.instruction), 0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("wait_valid", int'(bus.inst_valid), 0);
        check("wait_addr", int'(bus.inst_addr), 0);

        // Preload the counter to FFFE, then retire three instructions.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.count_load     = 1'b1;
        bus.count_load_val = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            pv = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, i + 1, 32'h0000FFFF};
            run_vec(pv, i);
        end
        check("sat_final", int'(bus.inst_count), 32'h0000FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
